// File: rtl/rob_pkg.sv
// Shared definitions for the multi-issue reorder buffer: index helpers and payload field map.
package rob_pkg;

   // Payload field layout within one ROB entry
   localparam int unsigned DEST_LSB  = 0;
   localparam int unsigned DEST_W    = 6;
   localparam int unsigned RRF_LSB   = DEST_LSB + DEST_W;
   localparam int unsigned RRF_W     = 7;
   localparam int unsigned PC_LSB    = RRF_LSB + RRF_W;
   localparam int unsigned PC_W      = 32;
   localparam int unsigned FLAGS_LSB = PC_LSB + PC_W;
   localparam int unsigned FLAGS_W   = 6;

   // Index width for n entries; never less than one bit
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Modulo-size increment; sizes need not be a power of two
   function automatic int unsigned wrap_add(input int unsigned idx, input int unsigned inc,
                                            input int unsigned size);
      return (idx + inc) % size;
   endfunction

endpackage

// File: rtl/rob_ptr_add.sv
// Produces LANES consecutive ROB indices starting at base, wrapping modulo SIZE.
module rob_ptr_add
   import rob_pkg::*;
#(
   parameter int unsigned SIZE  = 7,
   parameter int unsigned TAG_W = 3,
   parameter int unsigned LANES = 2
) (
   input  logic [TAG_W-1:0]       base,
   output logic [LANES*TAG_W-1:0] idx
);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign idx[i*TAG_W +: TAG_W] = TAG_W'(wrap_add(32'(base), 32'(i), SIZE));
   end

endmodule

// File: rtl/rob_multiport.sv
// N-wide dispatch, M-wide completion, K-wide in-order commit reorder buffer of arbitrary depth.
module rob_multiport
   import rob_pkg::*;
#(
   parameter int unsigned ROB_SIZE = 7,
   parameter int unsigned ENTRY_W  = 51,
   parameter int unsigned DISP_W   = 2,
   parameter int unsigned CPL_W    = 2,
   parameter int unsigned COMMIT_W = 2,
   parameter int unsigned TAG_W    = clog2(ROB_SIZE)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        stall,
   input  logic                        flush,
   input  logic [DISP_W-1:0]           disp_valid,
   input  logic [DISP_W*ENTRY_W-1:0]   disp_data,
   output logic [DISP_W-1:0]           disp_ready,
   output logic [DISP_W*TAG_W-1:0]     disp_tag,
   input  logic [CPL_W-1:0]            cpl_valid,
   input  logic [CPL_W*TAG_W-1:0]      cpl_tag,
   output logic [COMMIT_W-1:0]         commit_valid,
   output logic [COMMIT_W*ENTRY_W-1:0] commit_data,
   output logic [COMMIT_W*TAG_W-1:0]   commit_tag,
   output logic [TAG_W:0]              count,
   output logic                        empty,
   output logic                        full
);

   localparam int unsigned CNT_W = TAG_W + 1;

   logic [TAG_W-1:0]           head;
   logic [TAG_W-1:0]           tail;
   logic [ROB_SIZE-1:0]        valid;
   logic [ROB_SIZE-1:0]        done;
   logic [ENTRY_W-1:0]         mem [ROB_SIZE];
   logic [DISP_W*TAG_W-1:0]    tail_idx;
   logic [COMMIT_W*TAG_W-1:0]  head_idx;
   logic [DISP_W-1:0]          accept;
   logic [CNT_W-1:0]           free_slots;
   logic [CNT_W-1:0]           n_acc;
   logic [CNT_W-1:0]           n_ret;
   logic                       chain;

   rob_ptr_add #(.SIZE(ROB_SIZE), .TAG_W(TAG_W), .LANES(DISP_W)) u_tail_add (
      .base (tail),
      .idx  (tail_idx)
   );

   rob_ptr_add #(.SIZE(ROB_SIZE), .TAG_W(TAG_W), .LANES(COMMIT_W)) u_head_add (
      .base (head),
      .idx  (head_idx)
   );

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(ROB_SIZE));

   // Dispatch handshake: lane i fits when more than i slots are free at the start of the cycle
   always_comb begin
      disp_ready = '0;
      accept     = '0;
      n_acc      = '0;
      free_slots = CNT_W'(ROB_SIZE) - count;
      disp_tag   = tail_idx;
      for (int unsigned i = 0; i < DISP_W; i++) begin
         disp_ready[i] = !stall && !flush && (32'(free_slots) > i);
         accept[i]     = disp_valid[i] && disp_ready[i];
         n_acc         = n_acc + CNT_W'(accept[i]);
      end
   end

   // Commit: contiguous run of done entries from head; an unfinished entry blocks younger ones
   always_comb begin
      commit_valid = '0;
      commit_data  = '0;
      commit_tag   = '0;
      n_ret        = '0;
      chain        = !stall && !flush && !reset;
      for (int unsigned j = 0; j < COMMIT_W; j++) begin
         chain = chain && valid[head_idx[j*TAG_W +: TAG_W]] && done[head_idx[j*TAG_W +: TAG_W]]
                 && (32'(count) > j);
         commit_valid[j]                   = chain;
         commit_tag[j*TAG_W +: TAG_W]      = head_idx[j*TAG_W +: TAG_W];
         commit_data[j*ENTRY_W +: ENTRY_W] = mem[head_idx[j*TAG_W +: TAG_W]];
         n_ret = n_ret + CNT_W'(chain);
      end
   end

   // Pointer, occupancy and per-entry status update; completions land even while stalled
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
         done  <= '0;
      end else begin
         for (int unsigned p = 0; p < CPL_W; p++) begin
            if (cpl_valid[p] && (32'(cpl_tag[p*TAG_W +: TAG_W]) < ROB_SIZE)
                && valid[cpl_tag[p*TAG_W +: TAG_W]]) begin
               done[cpl_tag[p*TAG_W +: TAG_W]] <= 1'b1;
            end
         end
         for (int unsigned j = 0; j < COMMIT_W; j++) begin
            if (commit_valid[j]) begin
               valid[head_idx[j*TAG_W +: TAG_W]] <= 1'b0;
               done[head_idx[j*TAG_W +: TAG_W]]  <= 1'b0;
            end
         end
         for (int unsigned i = 0; i < DISP_W; i++) begin
            if (accept[i]) begin
               valid[tail_idx[i*TAG_W +: TAG_W]] <= 1'b1;
               done[tail_idx[i*TAG_W +: TAG_W]]  <= 1'b0;
            end
         end
         head  <= TAG_W'(wrap_add(32'(head), 32'(n_ret), ROB_SIZE));
         tail  <= TAG_W'(wrap_add(32'(tail), 32'(n_acc), ROB_SIZE));
         count <= count + n_acc - n_ret;
      end
   end

   // Payload RAM write for accepted lanes; contents survive reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DISP_W; i++) begin
            if (accept[i]) mem[tail_idx[i*TAG_W +: TAG_W]] <= disp_data[i*ENTRY_W +: ENTRY_W];
         end
      end
   end

endmodule

// File: tb/tb_rob_multiport.sv
// Self-checking bench for rob_multiport: directed table, corner sequences, random vs queue model.
module tb_rob_multiport;
   import rob_pkg::*;

   localparam int RS = 7;
   localparam int EW = 51;
   localparam int DW = 2;
   localparam int CW = 2;
   localparam int TW = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              stall;
   logic              flush;
   logic [DW-1:0]     disp_valid;
   logic [DW*EW-1:0]  disp_data;
   logic [DW-1:0]     disp_ready;
   logic [DW*TW-1:0]  disp_tag;
   logic [1:0]        cpl_valid;
   logic [2*TW-1:0]   cpl_tag;
   logic [CW-1:0]     commit_valid;
   logic [CW*EW-1:0]  commit_data;
   logic [CW*TW-1:0]  commit_tag;
   logic [TW:0]       count;
   logic              empty;
   logic              full;

   always #5 clk = ~clk;

   rob_multiport #(.ROB_SIZE(RS), .ENTRY_W(EW), .DISP_W(DW), .CPL_W(2), .COMMIT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .disp_valid   (disp_valid),
      .disp_data    (disp_data),
      .disp_ready   (disp_ready),
      .disp_tag     (disp_tag),
      .cpl_valid    (cpl_valid),
      .cpl_tag      (cpl_tag),
      .commit_valid (commit_valid),
      .commit_data  (commit_data),
      .commit_tag   (commit_tag),
      .count        (count),
      .empty        (empty),
      .full         (full)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: queue of in-flight entries, oldest first
   typedef struct {
      int            tag;
      logic [EW-1:0] data;
      bit            done;
   } ent_t;

   ent_t          q[$];
   int            m_head = 0;
   int            p_acc, p_ret;
   logic [EW-1:0] p_data [DW];
   logic [1:0]    p_cv;
   int            p_ct [2];
   logic          p_flush;

   typedef struct {
      logic       st;
      logic [1:0] dv;
      logic [1:0] cv;
      int         ct0;
      int         ct1;
      logic [1:0] er;
      int         t0;
      int         t1;
      logic [1:0] ecv;
      int         ect0;
      int         ecnt;
   } vec_t;

   vec_t vt[17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] rand_payload();
      logic [EW-1:0] d;
      d = '0;
      d[DEST_LSB +: DEST_W]   = DEST_W'($urandom);
      d[RRF_LSB +: RRF_W]     = RRF_W'($urandom);
      d[PC_LSB +: PC_W]       = $urandom;
      d[FLAGS_LSB +: FLAGS_W] = FLAGS_W'($urandom);
      return d;
   endfunction

   // Apply one cycle of inputs and compare every output with the model's prediction
   task automatic drive(input logic st, input logic fl, input logic [1:0] dv,
                        input logic [1:0] cv, input int ct0, input int ct1);
      int         tl, n;
      logic [1:0] er, ecv;
      stall      = st;
      flush      = fl;
      disp_valid = dv;
      cpl_valid  = cv;
      cpl_tag    = {3'(ct1), 3'(ct0)};
      disp_data  = {rand_payload(), rand_payload()};
      #1;
      tl = (m_head + q.size()) % RS;
      er = '0;
      for (int i = 0; i < DW; i++) er[i] = !st && !fl && ((RS - q.size()) > i);
      chk("disp_ready", 64'(disp_ready), 64'(er));
      for (int i = 0; i < DW; i++) chk("disp_tag", 64'(disp_tag[i*TW +: TW]), 64'((tl + i) % RS));
      n = 0;
      if (!st && !fl) begin
         while (n < CW && n < q.size() && q[n].done) n++;
      end
      ecv = 2'((1 << n) - 1);
      chk("commit_valid", 64'(commit_valid), 64'(ecv));
      for (int j = 0; j < n; j++) begin
         chk("commit_tag", 64'(commit_tag[j*TW +: TW]), 64'(q[j].tag));
         chk("commit_data", 64'(commit_data[j*EW +: EW]), 64'(q[j].data));
      end
      chk("count", 64'(count), 64'(q.size()));
      chk("empty", 64'(empty), 64'(q.size() == 0));
      chk("full", 64'(full), 64'(q.size() == RS));
      p_ret = n;
      p_acc = 0;
      for (int i = 0; i < DW; i++) begin
         if (dv[i] && er[i]) p_acc++;
         p_data[i] = disp_data[i*EW +: EW];
      end
      p_flush = fl;
      p_cv    = cv;
      p_ct[0] = ct0;
      p_ct[1] = ct1;
   endtask

   // Advance the model by the predicted cycle effect, then clock the DUT
   task automatic tick();
      int tl;
      if (p_flush) begin
         q.delete();
         m_head = 0;
      end else begin
         tl = (m_head + q.size()) % RS;
         for (int p = 0; p < 2; p++) begin
            if (p_cv[p]) begin
               foreach (q[k]) if (q[k].tag == p_ct[p]) q[k].done = 1'b1;
            end
         end
         repeat (p_ret) void'(q.pop_front());
         m_head = (m_head + p_ret) % RS;
         for (int i = 0; i < p_acc; i++) q.push_back('{(tl + i) % RS, p_data[i], 1'b0});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic st, input logic fl, input logic [1:0] dv,
                      input logic [1:0] cv, input int ct0, input int ct1);
      drive(st, fl, dv, cv, ct0, ct1);
      tick();
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      stall      = 1'b0;
      flush      = 1'b0;
      disp_valid = '0;
      cpl_valid  = '0;
      cpl_tag    = '0;
      disp_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      m_head = 0;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_ready", 64'(disp_ready), 64'd3);
      chk("rst_tag", 64'(disp_tag), 64'h08);
      chk("rst_commit", 64'(commit_valid), 64'd0);
   endtask

   initial begin
      // st, dv, cv, ct0, ct1, exp ready, exp tag0, exp tag1, exp commit_valid, exp ctag0, exp count
      vt[0]  = '{1'b0, 2'b11, 2'b00, 0, 0, 2'b11, 0, 1, 2'b00, 0, 0};
      vt[1]  = '{1'b0, 2'b11, 2'b00, 0, 0, 2'b11, 2, 3, 2'b00, 0, 2};
      vt[2]  = '{1'b0, 2'b11, 2'b00, 0, 0, 2'b11, 4, 5, 2'b00, 0, 4};
      vt[3]  = '{1'b0, 2'b11, 2'b00, 0, 0, 2'b01, 6, 0, 2'b00, 0, 6};
      vt[4]  = '{1'b0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 1, 2'b00, 0, 7};
      vt[5]  = '{1'b0, 2'b00, 2'b01, 2, 0, 2'b00, 0, 1, 2'b00, 0, 7};
      vt[6]  = '{1'b0, 2'b00, 2'b01, 1, 0, 2'b00, 0, 1, 2'b00, 0, 7};
      vt[7]  = '{1'b0, 2'b00, 2'b01, 0, 0, 2'b00, 0, 1, 2'b00, 0, 7};
      vt[8]  = '{1'b0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 1, 2'b11, 0, 7};
      vt[9]  = '{1'b0, 2'b00, 2'b00, 0, 0, 2'b11, 0, 1, 2'b01, 2, 5};
      vt[10] = '{1'b0, 2'b00, 2'b11, 3, 4, 2'b11, 0, 1, 2'b00, 0, 4};
      vt[11] = '{1'b1, 2'b00, 2'b01, 5, 0, 2'b00, 0, 1, 2'b00, 0, 4};
      vt[12] = '{1'b1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 1, 2'b00, 0, 4};
      vt[13] = '{1'b0, 2'b00, 2'b00, 0, 0, 2'b11, 0, 1, 2'b11, 3, 4};
      vt[14] = '{1'b0, 2'b00, 2'b01, 6, 0, 2'b11, 0, 1, 2'b01, 5, 2};
      vt[15] = '{1'b0, 2'b00, 2'b00, 0, 0, 2'b11, 0, 1, 2'b01, 6, 1};
      vt[16] = '{1'b0, 2'b00, 2'b00, 0, 0, 2'b11, 0, 1, 2'b00, 0, 0};

      do_reset();

      // Fill, out-of-order completion, in-order commit, stall
      for (int k = 0; k < 17; k++) begin
         drive(vt[k].st, 1'b0, vt[k].dv, vt[k].cv, vt[k].ct0, vt[k].ct1);
         chk("tbl_ready", 64'(disp_ready), 64'(vt[k].er));
         chk("tbl_tag0", 64'(disp_tag[0 +: TW]), 64'(vt[k].t0));
         chk("tbl_tag1", 64'(disp_tag[TW +: TW]), 64'(vt[k].t1));
         chk("tbl_commit", 64'(commit_valid), 64'(vt[k].ecv));
         if (vt[k].ecv[0]) chk("tbl_ctag0", 64'(commit_tag[0 +: TW]), 64'(vt[k].ect0));
         chk("tbl_count", 64'(count), 64'(vt[k].ecnt));
         tick();
      end

      // Wrap-around: bring head to 5, then dispatch and retire across the boundary
      cyc(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      cyc(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      cyc(1'b0, 1'b0, 2'b01, 2'b00, 0, 0);
      cyc(1'b0, 1'b0, 2'b00, 2'b11, 0, 1);
      cyc(1'b0, 1'b0, 2'b00, 2'b11, 2, 3);
      cyc(1'b0, 1'b0, 2'b00, 2'b01, 4, 0);
      cyc(1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
      drive(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      chk("wrap_tags_a", 64'(disp_tag), 64'({3'd6, 3'd5}));
      tick();
      drive(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      chk("wrap_tags_b", 64'(disp_tag), 64'({3'd1, 3'd0}));
      tick();
      cyc(1'b0, 1'b0, 2'b00, 2'b11, 5, 6);
      drive(1'b0, 1'b0, 2'b00, 2'b11, 0, 1);
      chk("wrap_cv_a", 64'(commit_valid), 64'd3);
      chk("wrap_ctag_a", 64'(commit_tag), 64'({3'd6, 3'd5}));
      tick();
      drive(1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
      chk("wrap_cv_b", 64'(commit_valid), 64'd3);
      chk("wrap_ctag_b", 64'(commit_tag), 64'({3'd1, 3'd0}));
      tick();

      // Flush with dispatch and completion in the same cycle
      cyc(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      cyc(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      cyc(1'b0, 1'b0, 2'b01, 2'b00, 0, 0);
      drive(1'b0, 1'b1, 2'b11, 2'b01, 4, 0);
      chk("flush_count_before", 64'(count), 64'd5);
      chk("flush_ready", 64'(disp_ready), 64'd0);
      chk("flush_cv", 64'(commit_valid), 64'd0);
      tick();
      drive(1'b0, 1'b0, 2'b00, 2'b01, 4, 0);
      chk("post_flush_count", 64'(count), 64'd0);
      chk("post_flush_empty", 64'(empty), 64'd1);
      chk("post_flush_cv", 64'(commit_valid), 64'd0);
      chk("post_flush_tag0", 64'(disp_tag[0 +: TW]), 64'd0);
      tick();
      drive(1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
      chk("stale_cpl_cv", 64'(commit_valid), 64'd0);
      chk("stale_cpl_count", 64'(count), 64'd0);
      tick();

      // Full with simultaneous commit: freed slot is reusable only next cycle
      cyc(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      cyc(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      cyc(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      cyc(1'b0, 1'b0, 2'b01, 2'b00, 0, 0);
      cyc(1'b0, 1'b0, 2'b00, 2'b01, 0, 0);
      drive(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      chk("full_flag", 64'(full), 64'd1);
      chk("full_ready", 64'(disp_ready), 64'd0);
      chk("full_cv", 64'(commit_valid), 64'd1);
      tick();
      drive(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      chk("refill_count", 64'(count), 64'd6);
      chk("refill_ready", 64'(disp_ready), 64'd1);
      chk("refill_tag0", 64'(disp_tag[0 +: TW]), 64'd0);
      tick();
      drive(1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
      chk("refill_full", 64'(full), 64'd1);
      tick();

      // Random traffic against the model, with one reset in the middle
      for (int c = 0; c < 400; c++) begin
         logic       st, fl;
         logic [1:0] dv;
         int         r;
         if (c == 200) do_reset();
         st = ($urandom % 10) == 0;
         fl = ($urandom % 40) == 0;
         r  = $urandom % 3;
         dv = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
         cyc(st, fl, dv, 2'($urandom), $urandom % RS, $urandom % RS);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
